fetch_unit: RTL and testbench

// - Instruction-fetch stage of the single-cycle CPU: owns the PC, drives the synchronous instruction

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_unit_if.sv | 22 ++
 rtl/fetch_skid_buf.sv | 34 +++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default address width, NOP encoding, opcode constants
// and the fetch-stage state type.
package cpu_pkg;

    localparam int ADDR_W_DEF = 12;

    // All-zero word decodes as R-type add $0,$0,$0: harmless when nothing is valid.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HELD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    function automatic logic [4:0] opcode_of(input logic [31:0] instr);
        return instr[31:27];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and a synchronous
// imem (slave). Handshake: the slave samples addr when rden=1 on a rising edge
// and returns q during the following cycle; there is no back-pressure.
interface fetch_unit_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W_DEF
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rden;
    logic [31:0]       imem_q;

    modport master (
        output imem_addr,
        output imem_rden,
        input  imem_q
    );

    modport slave (
        input  imem_addr,
        input  imem_rden,
        output imem_q
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding the word that returns from imem while the
// output register is stalled. A full entry is never overwritten.
module fetch_skid_buf
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              unload,
    input  logic              clear,
    input  logic [31:0]       load_data,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              valid,
    output logic [31:0]       data,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= NOP_INSTR;
            pc    <= '0;
        end else if (clear || unload) begin
            valid <= 1'b0;
        end else if (load && !valid) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, BOOT/RUN/HELD/FLUSH control, imem
// address/rden mux and the registered instruction presented to decode.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    fetch_unit_if.master      imem,
    output logic              instr_valid_o,
    output logic [31:0]       instr_o,
    output logic [4:0]        opcode_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic [ADDR_W-1:0] pc_plus1_o,
    output fetch_state_t      state_dbg
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;

    logic              advance;
    logic              skid_load;
    logic              skid_unload;
    logic              skid_valid;
    logic [31:0]       skid_data;
    logic [ADDR_W-1:0] skid_pc;

    assign advance = !stall_i || !instr_valid_o;

    // Leaving RUN-like states on a stall parks the returning word in the skid;
    // rden is dropped that same cycle so nothing else is in flight behind it.
    assign skid_load   = !redirect_i && (state != HELD) && !advance && inflight;
    assign skid_unload = !redirect_i && (state == HELD) && !stall_i;

    always_comb begin
        imem.imem_addr = fetch_pc;
        imem.imem_rden = 1'b1;
        if (redirect_i) begin
            imem.imem_addr = redirect_pc_i;
        end else if (state == HELD) begin
            imem.imem_rden = !stall_i;
        end else begin
            imem.imem_rden = advance;
        end
    end

    fetch_skid_buf #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .load      (skid_load),
        .unload    (skid_unload),
        .clear     (redirect_i),
        .load_data (imem.imem_q),
        .load_pc   (inflight_pc),
        .valid     (skid_valid),
        .data      (skid_data),
        .pc        (skid_pc)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= BOOT;
            fetch_pc      <= RESET_PC;
            inflight      <= 1'b0;
            inflight_pc   <= '0;
            instr_valid_o <= 1'b0;
            instr_o       <= NOP_INSTR;
            instr_pc_o    <= '0;
        end else if (redirect_i) begin
            state         <= FLUSH;
            fetch_pc      <= redirect_pc_i + ADDR_W'(1);
            inflight      <= 1'b1;
            inflight_pc   <= redirect_pc_i;
            instr_valid_o <= 1'b0;
            instr_o       <= NOP_INSTR;
        end else begin
            case (state)
                HELD: begin
                    if (!stall_i) begin
                        state         <= RUN;
                        instr_valid_o <= skid_valid;
                        instr_o       <= skid_valid ? skid_data : NOP_INSTR;
                        if (skid_valid) instr_pc_o <= skid_pc;
                        fetch_pc      <= fetch_pc + ADDR_W'(1);
                        inflight      <= 1'b1;
                        inflight_pc   <= fetch_pc;
                    end
                end
                default: begin
                    // BOOT and FLUSH always advance since nothing valid is held.
                    if (advance) begin
                        state         <= RUN;
                        instr_valid_o <= inflight;
                        instr_o       <= inflight ? imem.imem_q : NOP_INSTR;
                        if (inflight) instr_pc_o <= inflight_pc;
                        fetch_pc      <= fetch_pc + ADDR_W'(1);
                        inflight      <= 1'b1;
                        inflight_pc   <= fetch_pc;
                    end else begin
                        state    <= HELD;
                        inflight <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign opcode_o   = opcode_of(instr_o);
    assign pc_plus1_o = instr_pc_o + ADDR_W'(1);
    assign state_dbg  = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order fetch, stall/skid, redirect, redirect
// during hold, reset during hold, and PC wrap on a second RESET_PC=FFE instance.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int AW = 12;

  // clock / reset
  logic clock = 1'b0;
  logic reset_a = 1'b0;
  logic reset_b = 1'b0;
  always #5 clock = ~clock;

  // stimulus
  logic          stall_a = 1'b0;
  logic          redirect_a = 1'b0;
  logic [AW-1:0] redirect_pc_a = '0;

  // DUT A observation
  logic          valid_a;
  logic [31:0]   instr_a;
  logic [4:0]    op_a;
  logic [AW-1:0] pc_a;
  logic [AW-1:0] pc1_a;
  fetch_state_t  st_a;

  // DUT B observation
  logic          valid_b;
  logic [31:0]   instr_b;
  logic [4:0]    op_b;
  logic [AW-1:0] pc_b;
  logic [AW-1:0] pc1_b;
  fetch_state_t  st_b;

  fetch_unit_if #(.ADDR_W(AW)) imem_a ();
  fetch_unit_if #(.ADDR_W(AW)) imem_b ();

  logic [31:0] mem [4096];

  always @(posedge clock) if (imem_a.imem_rden) imem_a.imem_q <= mem[imem_a.imem_addr];
  always @(posedge clock) if (imem_b.imem_rden) imem_b.imem_q <= mem[imem_b.imem_addr];

  fetch_unit #(.ADDR_W(AW), .RESET_PC(12'h000)) dut_a (
    .clock         (clock),
    .reset         (reset_a),
    .stall_i       (stall_a),
    .redirect_i    (redirect_a),
    .redirect_pc_i (redirect_pc_a),
    .imem          (imem_a),
    .instr_valid_o (valid_a),
    .instr_o       (instr_a),
    .opcode_o      (op_a),
    .instr_pc_o    (pc_a),
    .pc_plus1_o    (pc1_a),
    .state_dbg     (st_a)
  );

  fetch_unit #(.ADDR_W(AW), .RESET_PC(12'hFFE)) dut_b (
    .clock         (clock),
    .reset         (reset_b),
    .stall_i       (1'b0),
    .redirect_i    (1'b0),
    .redirect_pc_i (12'h000),
    .imem          (imem_b),
    .instr_valid_o (valid_b),
    .instr_o       (instr_b),
    .opcode_o      (op_b),
    .instr_pc_o    (pc_b),
    .pc_plus1_o    (pc1_b),
    .state_dbg     (st_b)
  );

  // scoreboard counters
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h5000_0000 | i;
    mem[0] = 32'h2800_0011; // addi
    mem[1] = 32'h4000_0022; // lw
    mem[2] = 32'h3800_0033; // sw
    mem[3] = 32'h0022_0020; // R-type

    // reset values
    @(negedge clock);
    @(negedge clock);
    chk("rst_valid", 32'(valid_a), 32'h0);
    chk("rst_instr", instr_a, 32'h0);
    chk("rst_pc", 32'(pc_a), 32'h0);
    chk("rst_pc1", 32'(pc1_a), 32'h1);
    chk("rst_state", 32'(st_a), 32'(BOOT));
    chk("rst_b_addr", 32'(imem_b.imem_addr), 32'hFFE);

    // release: first fetch issued immediately
    reset_a = 1'b1;
    #1;
    chk("boot_rden", 32'(imem_a.imem_rden), 32'h1);
    chk("boot_addr", 32'(imem_a.imem_addr), 32'h0);
    step();
    chk("e1_valid", 32'(valid_a), 32'h0);
    chk("e1_state", 32'(st_a), 32'(RUN));
    chk("e1_addr", 32'(imem_a.imem_addr), 32'h1);
    step();
    chk("e2_valid", 32'(valid_a), 32'h1);
    chk("e2_instr", instr_a, 32'h2800_0011);
    chk("e2_pc", 32'(pc_a), 32'h0);
    chk("e2_op", 32'(op_a), 32'(OP_ADDI));
    chk("e2_pc1", 32'(pc1_a), 32'h1);
    step();
    chk("e3_valid", 32'(valid_a), 32'h1);
    chk("e3_instr", instr_a, 32'h4000_0022);
    chk("e3_pc", 32'(pc_a), 32'h1);
    chk("e3_op", 32'(op_a), 32'(OP_LW));
    step();
    chk("e4_instr", instr_a, 32'h3800_0033);
    chk("e4_pc", 32'(pc_a), 32'h2);
    chk("e4_op", 32'(op_a), 32'(OP_SW));

    // stall three cycles while pc=2
    stall_a = 1'b1;
    #1;
    chk("stall1_rden", 32'(imem_a.imem_rden), 32'h0);
    step();
    chk("stall_e5_pc", 32'(pc_a), 32'h2);
    chk("stall_e5_instr", instr_a, 32'h3800_0033);
    chk("stall_e5_state", 32'(st_a), 32'(HELD));
    chk("stall_e5_rden", 32'(imem_a.imem_rden), 32'h0);
    step();
    chk("stall_e6_pc", 32'(pc_a), 32'h2);
    step();
    chk("stall_e7_pc", 32'(pc_a), 32'h2);
    chk("stall_e7_valid", 32'(valid_a), 32'h1);
    stall_a = 1'b0;
    #1;
    chk("rel_rden", 32'(imem_a.imem_rden), 32'h1);
    chk("rel_addr", 32'(imem_a.imem_addr), 32'h4);
    step();
    chk("e8_pc", 32'(pc_a), 32'h3);
    chk("e8_instr", instr_a, 32'h0022_0020);
    chk("e8_op", 32'(op_a), 32'(OP_RTYPE));
    chk("e8_valid", 32'(valid_a), 32'h1);
    step();
    chk("e9_pc", 32'(pc_a), 32'h4);
    chk("e9_instr", instr_a, 32'h5000_0004);
    step();
    chk("e10_pc", 32'(pc_a), 32'h5);

    // redirect in RUN
    redirect_a = 1'b1;
    redirect_pc_a = 12'h100;
    #1;
    chk("redir_addr", 32'(imem_a.imem_addr), 32'h100);
    chk("redir_rden", 32'(imem_a.imem_rden), 32'h1);
    step();
    redirect_a = 1'b0;
    chk("flush_valid", 32'(valid_a), 32'h0);
    chk("flush_instr", instr_a, 32'h0);
    chk("flush_state", 32'(st_a), 32'(FLUSH));
    #1;
    chk("flush_addr", 32'(imem_a.imem_addr), 32'h101);
    step();
    chk("tgt0_pc", 32'(pc_a), 32'h100);
    chk("tgt0_instr", instr_a, 32'h5000_0100);
    chk("tgt0_valid", 32'(valid_a), 32'h1);
    step();
    chk("tgt1_pc", 32'(pc_a), 32'h101);

    // redirect together with stall while HELD
    stall_a = 1'b1;
    step();
    chk("held_state", 32'(st_a), 32'(HELD));
    chk("held_pc", 32'(pc_a), 32'h101);
    step();
    redirect_a = 1'b1;
    redirect_pc_a = 12'h200;
    #1;
    chk("hredir_addr", 32'(imem_a.imem_addr), 32'h200);
    chk("hredir_rden", 32'(imem_a.imem_rden), 32'h1);
    step();
    redirect_a = 1'b0;
    chk("hflush_valid", 32'(valid_a), 32'h0);
    chk("hflush_state", 32'(st_a), 32'(FLUSH));
    step();
    chk("htgt_valid", 32'(valid_a), 32'h1);
    chk("htgt_pc", 32'(pc_a), 32'h200);
    chk("htgt_instr", instr_a, 32'h5000_0200);
    #1;
    chk("htgt_rden", 32'(imem_a.imem_rden), 32'h0);
    step();
    chk("held2_state", 32'(st_a), 32'(HELD));
    chk("held2_pc", 32'(pc_a), 32'h200);

    // asynchronous reset while stalled with a full skid
    reset_a = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_a), 32'h0);
    chk("arst_instr", instr_a, 32'h0);
    chk("arst_pc", 32'(pc_a), 32'h0);
    chk("arst_pc1", 32'(pc1_a), 32'h1);
    chk("arst_state", 32'(st_a), 32'(BOOT));
    chk("arst_addr", 32'(imem_a.imem_addr), 32'h0);
    step();
    stall_a = 1'b0;
    reset_a = 1'b1;
    step();
    chk("rs_e1_valid", 32'(valid_a), 32'h0);
    step();
    chk("rs_e2_valid", 32'(valid_a), 32'h1);
    chk("rs_e2_pc", 32'(pc_a), 32'h0);
    chk("rs_e2_instr", instr_a, 32'h2800_0011);
    step();
    chk("rs_e3_pc", 32'(pc_a), 32'h1);
    chk("rs_e3_instr", instr_a, 32'h4000_0022);

    // wrap on the RESET_PC=FFE instance
    reset_b = 1'b1;
    step();
    chk("wb_e1_valid", 32'(valid_b), 32'h0);
    step();
    chk("wb_e2_pc", 32'(pc_b), 32'hFFE);
    chk("wb_e2_pc1", 32'(pc1_b), 32'hFFF);
    chk("wb_e2_instr", instr_b, 32'h5000_0FFE);
    chk("wb_e2_valid", 32'(valid_b), 32'h1);
    step();
    chk("wb_e3_pc", 32'(pc_b), 32'hFFF);
    chk("wb_e3_pc1", 32'(pc1_b), 32'h000);
    chk("wb_e3_instr", instr_b, 32'h5000_0FFF);
    step();
    chk("wb_e4_pc", 32'(pc_b), 32'h000);
    chk("wb_e4_pc1", 32'(pc1_b), 32'h001);
    chk("wb_e4_instr", instr_b, 32'h2800_0011);
    chk("wb_e4_op", 32'(op_b), 32'(OP_ADDI));
    chk("wb_e4_state", 32'(st_b), 32'(RUN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
